// File: rtl/aluout_capture_buffer_if.sv
// Bus between the ALU-result capture buffer and its controller/reader.
// Carries the sampled bus, the window controls, the drain handshake and the status flags.
interface aluout_capture_buffer_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] aluout;
   logic             arm;
   logic [7:0]       skip;
   logic             rd_ready;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic [CW-1:0]    count;
   logic             busy;
   logic             done;
   logic             overflow;

   modport master (
      output aluout, arm, skip, rd_ready,
      input  rd_valid, rd_data, count, busy, done, overflow
   );

   modport slave (
      input  aluout, arm, skip, rd_ready,
      output rd_valid, rd_data, count, busy, done, overflow
   );
endinterface

// File: rtl/aluout_capture_buffer.sv
// Captures a window of pipeline aluout samples into a first-word-fall-through FIFO.
// Define ALUOUT_CAP_CHANGE_ONLY_EN to push only samples that differ from the previous cycle.
module aluout_capture_buffer #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CAP_LEN = 8
) (
   input logic                    clk,
   input logic                    rst,
   aluout_capture_buffer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

   state_t         state, state_nx;
   logic [7:0]     skip_cnt, skip_cnt_nx;
   logic [7:0]     att_cnt, att_cnt_nx;
   logic           sample_c;
   logic           arm_ok_c;
   logic           want_push_c;
   logic           push_c;
   logic           pop_c;
   logic           full_c;
   logic [CW-1:0]  count_nx;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Window controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         skip_cnt <= 8'd0;
         att_cnt  <= 8'd0;
      end else begin
         state    <= state_nx;
         skip_cnt <= skip_cnt_nx;
         att_cnt  <= att_cnt_nx;
      end
   end

   // Window next-state: skip countdown, then CAP_LEN sample attempts
   always_comb begin
      state_nx    = state;
      skip_cnt_nx = skip_cnt;
      att_cnt_nx  = att_cnt;
      sample_c    = 1'b0;
      arm_ok_c    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.arm) begin
               arm_ok_c    = 1'b1;
               att_cnt_nx  = 8'd0;
               skip_cnt_nx = bus.skip;
               state_nx    = (bus.skip == 8'd0) ? S_CAPTURE : S_SKIP;
            end
         end
         S_SKIP: begin
            skip_cnt_nx = skip_cnt - 8'd1;
            if (skip_cnt == 8'd1) state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            sample_c   = 1'b1;
            att_cnt_nx = att_cnt + 8'd1;
            if (att_cnt == 8'(CAP_LEN - 1)) state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef ALUOUT_CAP_CHANGE_ONLY_EN
   logic [WIDTH-1:0] prev_aluout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_aluout <= '0;
      else     prev_aluout <= bus.aluout;
   end

   // First attempt of a window always pushes; later ones only on a change
   assign want_push_c = sample_c && ((att_cnt == 8'd0) || (bus.aluout != prev_aluout));
`else
   assign want_push_c = sample_c;
`endif

   assign pop_c  = bus.rd_valid && bus.rd_ready;
   assign full_c = (bus.count == CW'(DEPTH));
   assign push_c = want_push_c && (!full_c || pop_c);

   always_comb begin
      count_nx = bus.count;
      case ({push_c, pop_c})
         2'b10:   count_nx = bus.count + CW'(1);
         2'b01:   count_nx = bus.count - CW'(1);
         default: count_nx = bus.count;
      endcase
   end

   // Storage array needs no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= bus.aluout;
   end

   // Pointers, occupancy and the registered fall-through head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.count    <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         bus.count    <= count_nx;
         bus.rd_valid <= (count_nx != '0);
         if (push_c && ((bus.count == '0) || (pop_c && bus.count == CW'(1))))
            bus.rd_data <= bus.aluout;
         else if (pop_c && bus.count > CW'(1))
            bus.rd_data <= mem[rd_ptr + AW'(1)];
      end
   end

   // Status flags; overflow is sticky until the next accepted arm
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         bus.busy <= (state_nx == S_SKIP) || (state_nx == S_CAPTURE);
         bus.done <= (state_nx == S_DONE);
         if (arm_ok_c)
            bus.overflow <= 1'b0;
         else if (want_push_c && full_c && !pop_c)
            bus.overflow <= 1'b1;
      end
   end
endmodule
